// File: rtl/exec_step_controller.sv
// Step/run/breakpoint controller for the single-cycle core: turns debounced button pulses into a
// one-cycle registered exec enable, and also owns the data-memory browse pointer and issue counter.
module exec_step_controller #(
  parameter int ADDR_W      = 5,
  parameter int DM_ADDR_W   = 4,
  parameter int RATE_DIV    = 25000000,
  parameter int BROWSE_WRAP = 1,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_pulse,
  input  logic                 run_pulse,
  input  logic                 inc_pulse,
  input  logic                 dec_pulse,
  input  logic                 bp_enable,
  input  logic [ADDR_W-1:0]    bp_addr,
  input  logic [ADDR_W-1:0]    curr_inst_addr,
  input  logic                 halt,
  output logic                 exec_en,
  output logic [DM_ADDR_W-1:0] browse_addr,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     step_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_BREAK  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam int DIV_W = $clog2(RATE_DIV);
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(RATE_DIV - 1);
  localparam logic [DM_ADDR_W-1:0] BR_MAX   = '1;
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

  logic [1:0]           state_n;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     div_n;
  logic                 skip_q;
  logic                 skip_n;
  logic                 issue;
  logic                 bp_hit;
  logic [DM_ADDR_W-1:0] browse_n;

  assign bp_hit = bp_enable && (curr_inst_addr == bp_addr);

  // The divider only advances in RUN; every other path leaves it cleared.
  always_comb begin
    state_n = state;
    div_n   = '0;
    skip_n  = skip_q;
    issue   = 1'b0;
    case (state)
      S_IDLE: begin
        if (run_pulse) begin
          state_n = S_RUN;
          skip_n  = 1'b1;
        end else if (step_pulse) begin
          issue = 1'b1;
        end
      end
      S_RUN: begin
        if (run_pulse) begin
          state_n = S_IDLE;
        end else if (div_q == DIV_LAST) begin
          if (bp_hit && !skip_q) begin
            state_n = S_BREAK;
          end else begin
            issue  = 1'b1;
            skip_n = 1'b0;
          end
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (run_pulse) begin
          state_n = S_RUN;
          skip_n  = 1'b1;
        end else if (step_pulse) begin
          issue   = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: ;
    endcase
    if (halt) begin
      state_n = S_HALTED;
      issue   = 1'b0;
    end
    // A held step input would otherwise issue back-to-back; the core needs a gap.
    if (exec_en) begin
      issue = 1'b0;
    end
  end

  always_comb begin
    browse_n = browse_addr;
    if (inc_pulse && !dec_pulse) begin
      if (BROWSE_WRAP != 0 || browse_addr != BR_MAX) begin
        browse_n = browse_addr + 1'b1;
      end
    end else if (dec_pulse && !inc_pulse) begin
      if (BROWSE_WRAP != 0 || browse_addr != '0) begin
        browse_n = browse_addr - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      div_q       <= '0;
      skip_q      <= 1'b0;
      exec_en     <= 1'b0;
      browse_addr <= '0;
      step_count  <= '0;
    end else begin
      state       <= state_n;
      div_q       <= div_n;
      skip_q      <= skip_n;
      exec_en     <= issue;
      browse_addr <= browse_n;
      if (exec_en && step_count != CNT_MAX) begin
        step_count <= step_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/exec_step_controller.md
Name: exec_step_controller

Overview:
- Parametrised execution/debug controller for the single-cycle MIPS core on the FPGA board. It replaces the fixed button-to-PC-enable wiring.
- Consumes one-cycle debounced pulses and produces the PC/core execute enable.
- Adds three behaviours the fixed wiring lacks: free-running RUN mode at a divided rate, an instruction-address breakpoint, and a sticky HALTED state.
- Also owns the data-memory browse pointer (wrap or saturate) and a saturating executed-instruction counter for the display.

Parameters:
- ADDR_W, 5, instruction address width (curr_inst_addr, bp_addr).
- DM_ADDR_W, 4, data-memory browse address width.
- RATE_DIV, 25000000, clk cycles per issued instruction in RUN; legal range >= 2.
- BROWSE_WRAP, 1, 1 = browse_addr wraps modulo 2^DM_ADDR_W; 0 = saturates at 0 and 2^DM_ADDR_W-1.
- CNT_W, 16, step_count width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- step_pulse  in  1  one-cycle pulse: execute one instruction.
- run_pulse  in  1  one-cycle pulse: toggle run/pause; resume from break.
- inc_pulse  in  1  one-cycle pulse: browse_addr + 1.
- dec_pulse  in  1  one-cycle pulse: browse_addr - 1.
- bp_enable  in  1  breakpoint armed.
- bp_addr  in  ADDR_W  breakpoint instruction address.
- curr_inst_addr  in  ADDR_W  current PC value from the core.
- halt  in  1  halt decode of the current instruction from the core.
- exec_en  out  1  registered, one-cycle enable to PC/core.
- browse_addr  out  DM_ADDR_W  data-memory display read address.
- state  out  2  IDLE=0, RUN=1, BREAK=2, HALTED=3.
- step_count  out  CNT_W  instructions issued, saturating.

Behaviour:
- Reset (async, any time, including mid-RUN): state=IDLE, exec_en=0, browse_addr=0, step_count=0, divider=0, skip_bp=0. Takes effect immediately; no pending issue survives reset.
- Issue: exec_en is asserted one cycle after the triggering decision edge (all outputs registered) and is exactly one cycle wide. It is never asserted in consecutive cycles.
- Halt priority: halt=1 sampled in any state moves the FSM to HALTED and suppresses any issue decided in that cycle. HALTED exits only via reset.
- IDLE:
  - run_pulse -> RUN; divider=0; skip_bp=1.
  - else step_pulse -> issue one instruction; stay IDLE.
  - run_pulse and step_pulse in the same cycle: run wins, step is dropped.
  - Breakpoints are ignored for manual steps.
- RUN:
  - Divider counts 0..RATE_DIV-1 and wraps to 0. At terminal count an issue decision is made.
  - Breakpoint hit: if bp_enable && curr_inst_addr==bp_addr && !skip_bp -> BREAK, no issue.
  - Otherwise -> issue, and clear skip_bp.
  - run_pulse in RUN -> IDLE; divider=0; any issue due in the same cycle is dropped.
  - step_pulse in RUN is ignored.
- BREAK:
  - run_pulse -> RUN with divider=0 and skip_bp=1, so the breakpointed instruction executes on the first issue.
  - step_pulse -> issue one instruction, then -> IDLE.
  - Both in the same cycle: run wins.
- RATE_DIV >= 2 guarantees curr_inst_addr has updated after an issue before the next breakpoint compare.
- step_count: +1 on every cycle exec_en=1; holds at 2^CNT_W-1 (no wrap).
- Browse (independent of FSM, active in all states including HALTED):
  - inc alone -> +1; dec alone -> -1; inc and dec together -> no change.
  - BROWSE_WRAP=1: max+1 -> 0 and 0-1 -> max.
  - BROWSE_WRAP=0: clamp at 0 and at max.
- Input pulses are assumed to be already debounced and one cycle wide. A held-high input re-triggers every cycle, so no edge detect is performed internally.

Test Plan:
- RATE_DIV=4. Reset; step_pulse at cycle 10 -> exec_en=1 at cycle 11 only; step_count=1; state=0.
- run_pulse, curr_inst_addr advanced by the bench on each exec_en, bp_enable=0 -> exec_en every 4th cycle. After 5 issues, step_count=5. A second run_pulse -> state=0 with no further exec_en.
- bp_enable=1, bp_addr=3, run from addr 0:
  - Issues at addr 0,1,2, then state=2 with curr_inst_addr=3 and no exec_en.
  - run_pulse -> addr 3 executes (skip_bp), continues to 4.
  - step_pulse in BREAK instead -> one exec_en, state=0.
- halt=1 raised while in RUN one cycle before terminal count -> state=3, no exec_en. step_pulse/run_pulse have no effect. reset -> state=0, step_count=0.
- BROWSE_WRAP=1: dec at 0 -> 15; inc at 15 -> 0. BROWSE_WRAP=0: dec at 0 -> 0; inc at 15 -> 15. inc+dec together -> unchanged.
- CNT_W=3: 9 steps -> step_count=7 holds. reset asserted mid-RUN between edges -> outputs zero immediately (asynchronously).
